// File: rtl/cnn_layer_accel_ce_macc_pkg.sv
`default_nettype none
//============================================================================
// Module   : cnn_layer_accel_ce_macc_pkg
// Purpose  : Shared definitions for the CE MACC sequencer. Holds the DSP48E2
//            OPMODE/ALUMODE codes, the per-beat pipeline tag and the
//            sequencer state encoding. Also holds the OPMODE decode helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//============================================================================
package cnn_layer_accel_ce_macc_pkg;

  // OPMODE = {W[1:0], Z[2:0], Y[1:0], X[1:0]}
  localparam logic [8:0] OPMODE_LOAD_M = 9'b000000101; // P = M
  localparam logic [8:0] OPMODE_ACC_M  = 9'b000100101; // P = P + M
  localparam logic [8:0] OPMODE_HOLD   = 9'b000100000; // P = P
  localparam logic [8:0] OPMODE_BIAS_M = 9'b000110101; // P = C + M
  localparam logic [8:0] OPMODE_RESET  = 9'b000000000;
  localparam logic [3:0] ALUMODE_SUM   = 4'b0000;      // Z + W + X + Y

  // One tag travels alongside each operand beat through the slice stages.
  typedef struct packed {
    logic valid;     // real beat (0 = bubble)
    logic first;     // first beat of a dot product
    logic last;      // last beat of a dot product
    logic job_last;  // last beat of the last dot product of the job
  } macc_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } macc_state_t;

  // OPMODE for the beat currently sitting in the stage that feeds OPMODEREG.
  function automatic logic [8:0] opmode_decode(input macc_tag_t tag,
                                               input logic      bias_en);
    logic [8:0] op;
    if (!tag.valid) begin
      op = OPMODE_HOLD;
    end else if (!tag.first) begin
      op = OPMODE_ACC_M;
    end else if (bias_en) begin
      op = OPMODE_BIAS_M;
    end else begin
      op = OPMODE_LOAD_M;
    end
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_layer_accel_ce_macc_ctrl_if.sv
`default_nettype none
//============================================================================
// Module   : cnn_layer_accel_ce_macc_ctrl_if
// Purpose  : Operand-in / result-out handshake bundle of the CE MACC
//            sequencer.
// Signals  : in_valid  operand beat present on slice A/B
//            in_ready  sequencer accepts the beat
//            out_valid slice P holds a final dot product
//            out_ready consumer takes P
//            out_last  final dot product of the job (qualifies out_valid)
// Modports : master - the sequencer; slave - fetch logic / result consumer
// Revision : 1.0 - initial release
//============================================================================
interface cnn_layer_accel_ce_macc_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic out_last;

  modport master (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_last
  );

  modport slave (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_last
  );
endinterface
`default_nettype wire

// File: rtl/cnn_layer_accel_ce_macc_tag_pipe.sv
`default_nettype none
//============================================================================
// Module   : cnn_layer_accel_ce_macc_tag_pipe
// Purpose  : C_MACC_LAT-deep enabled shift register of beat tags. Stage k
//            mirrors DSP slice stage k (A1, A2, M, P), so it must advance on
//            exactly the same enable as the slice CE.
// Ports    : CLK      clock
//            rst      synchronous active-low reset (clears all stages)
//            en       shift enable (slice CE)
//            tag_in   tag of the beat entering stage 0
//            tag_opm  stage C_OPM_STAGE tag (drives OPMODE decode)
//            tag_out  last stage tag (aligned with P)
// Revision : 1.0 - initial release
//============================================================================
module cnn_layer_accel_ce_macc_tag_pipe
  import cnn_layer_accel_ce_macc_pkg::*;
#(
  parameter int C_MACC_LAT  = 4,
  parameter int C_OPM_STAGE = 1
) (
  input  wire logic      CLK,
  input  wire logic      rst,
  input  wire logic      en,
  input  wire macc_tag_t tag_in,
  output macc_tag_t      tag_opm,
  output macc_tag_t      tag_out
);

  macc_tag_t [C_MACC_LAT-1:0] r_tag;

  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_tag <= '0;
    end else if (en) begin
      r_tag <= {r_tag[C_MACC_LAT-2:0], tag_in};
    end
  end

  assign tag_opm = r_tag[C_OPM_STAGE];
  assign tag_out = r_tag[C_MACC_LAT-1];

endmodule
`default_nettype wire

// File: rtl/cnn_layer_accel_ce_macc_ctrl.sv
`default_nettype none
//============================================================================
// Module   : cnn_layer_accel_ce_macc_ctrl
// Purpose  : Sequences one CE MACC DSP48E2 slice (AREG=2, MREG=1, PREG=1,
//            OPMODEREG=1, ALUMODEREG=1). Groups every cfg_num_macc accepted
//            operand beats into one dot product, flags P when a sum is final
//            and owns all pipeline alignment and backpressure.
// Config   : `define CE_MACC_BIAS_EN adds bias_valid_cfg; when latched high
//            the first beat of each dot product uses P = C + M.
// Ports    : CLK          clock
//            rst          synchronous active-low reset
//            start        1-cycle job start (honoured only in IDLE)
//            cfg_num_macc beats per dot product (0 treated as 1)
//            cfg_num_out  dot products per job (0 treated as 1)
//            bias_valid_cfg (CE_MACC_BIAS_EN only) fold C bias into sums
//            busy / done  job status; done pulses once after final output
//            bus          operand / result handshake (master modport)
//            dsp_ce, dsp_rst, dsp_opmode, dsp_alumode  slice controls
// Revision : 1.0 - initial release
//============================================================================
module cnn_layer_accel_ce_macc_ctrl
  import cnn_layer_accel_ce_macc_pkg::*;
#(
  parameter int C_CNT_WIDTH = 16,
  parameter int C_MACC_LAT  = 4
) (
  input  wire logic                   CLK,
  input  wire logic                   rst,
  input  wire logic                   start,
  input  wire logic [C_CNT_WIDTH-1:0] cfg_num_macc,
  input  wire logic [C_CNT_WIDTH-1:0] cfg_num_out,
`ifdef CE_MACC_BIAS_EN
  input  wire logic                   bias_valid_cfg,
`endif
  output logic                        busy,
  output logic                        done,
  cnn_layer_accel_ce_macc_ctrl_if.master bus,
  output logic                        dsp_ce,
  output logic                        dsp_rst,
  output logic [8:0]                  dsp_opmode,
  output logic [3:0]                  dsp_alumode
);

  // Tag stage whose beat is being multiplied into M; its OPMODE must be
  // presented now so OPMODEREG captures it on the same edge as MREG.
  localparam int C_OPM_STAGE = 1;

  macc_state_t             r_state;
  logic                    r_busy;
  logic                    r_done;
  logic [C_CNT_WIDTH-1:0]  r_num_macc_m1;
  logic [C_CNT_WIDTH-1:0]  r_num_out_m1;
  logic [C_CNT_WIDTH-1:0]  r_macc_cnt;
  logic [C_CNT_WIDTH-1:0]  r_out_cnt;

  macc_tag_t               w_push;
  macc_tag_t               w_tag_opm;
  macc_tag_t               w_tag_out;
  logic                    w_out_valid;
  logic                    w_ce;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_out_fire;
  logic                    w_beat_last;
  logic                    w_job_last;
  logic                    w_bias_en;
  logic                    w_unused_tag_bits;

`ifdef CE_MACC_BIAS_EN
  logic                    r_bias;
  assign w_bias_en = r_bias;
`else
  assign w_bias_en = 1'b0;
`endif

  // A final result parked in P with no taker freezes the whole slice and
  // the tag pipe together, which also blocks new beats via in_ready.
  assign w_out_valid = w_tag_out.valid & w_tag_out.last;
  assign w_ce        = ~(w_out_valid & ~bus.out_ready);
  assign w_in_ready  = (r_state == ST_RUN) & w_ce;
  assign w_accept    = w_in_ready & bus.in_valid;
  assign w_out_fire  = w_out_valid & bus.out_ready;
  assign w_beat_last = (r_macc_cnt == r_num_macc_m1);
  assign w_job_last  = (r_out_cnt == r_num_out_m1);

  // Tag entering stage 0: a described beat on accept, otherwise a bubble.
  always_comb begin
    w_push = '0;
    if (w_accept) begin
      w_push.valid    = 1'b1;
      w_push.first    = (r_macc_cnt == '0);
      w_push.last     = w_beat_last;
      w_push.job_last = w_beat_last & w_job_last;
    end
  end

  cnn_layer_accel_ce_macc_tag_pipe #(
    .C_MACC_LAT  (C_MACC_LAT),
    .C_OPM_STAGE (C_OPM_STAGE)
  ) u_tag_pipe (
    .CLK     (CLK),
    .rst     (rst),
    .en      (w_ce),
    .tag_in  (w_push),
    .tag_opm (w_tag_opm),
    .tag_out (w_tag_out)
  );

  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_num_macc_m1 <= '0;
      r_num_out_m1  <= '0;
      r_macc_cnt    <= '0;
      r_out_cnt     <= '0;
`ifdef CE_MACC_BIAS_EN
      r_bias        <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state       <= ST_RUN;
            r_busy        <= 1'b1;
            // Stored as count-1 so a zero setting collapses onto one.
            r_num_macc_m1 <= (cfg_num_macc == '0) ? '0 : cfg_num_macc - 1'b1;
            r_num_out_m1  <= (cfg_num_out == '0)  ? '0 : cfg_num_out - 1'b1;
            r_macc_cnt    <= '0;
            r_out_cnt     <= '0;
`ifdef CE_MACC_BIAS_EN
            r_bias        <= bias_valid_cfg;
`endif
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (w_beat_last) begin
              r_macc_cnt <= '0;
              r_out_cnt  <= r_out_cnt + 1'b1;
              if (w_job_last) begin
                r_state <= ST_DRAIN;
              end
            end else begin
              r_macc_cnt <= r_macc_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_out_fire && w_tag_out.job_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // OPMODE is forced to zero while reset is asserted so the slice sees a
  // clean control word together with its RST pins.
  always_comb begin
    dsp_opmode = OPMODE_RESET;
    if (rst) begin
      dsp_opmode = opmode_decode(w_tag_opm, w_bias_en);
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_valid & w_tag_out.job_last;
  assign dsp_ce        = w_ce;
  assign dsp_rst       = ~rst;
  assign dsp_alumode   = ALUMODE_SUM;

  // Tag fields that are carried for alignment but not consumed here.
  assign w_unused_tag_bits = ^{w_tag_opm.last, w_tag_opm.job_last, w_tag_out.first};

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_accel_ce_macc_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_cnn_layer_accel_ce_macc_ctrl
// Purpose  : Self-checking bench for cnn_layer_accel_ce_macc_ctrl. Drives a
//            behavioural DSP slice from the controller outputs and compares
//            each delivered P against dot products computed from the
//            accepted beats.
// Revision : 1.0 - initial release
//============================================================================
module tb_cnn_layer_accel_ce_macc_ctrl;
  import cnn_layer_accel_ce_macc_pkg::*;

  localparam int          CW     = 16;
  localparam logic [47:0] C_BIAS = 48'd100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_num_macc = '0;
  logic [CW-1:0] cfg_num_out = '0;
  logic          bias_valid_cfg = 1'b0;
  logic          busy, done, dsp_ce, dsp_rst;
  logic [8:0]    dsp_opmode;
  logic [3:0]    dsp_alumode;
  logic [15:0]   a_in = '0;
  logic [15:0]   b_in = '0;

  cnn_layer_accel_ce_macc_ctrl_if bus();

  always #5 clk = ~clk;

  cnn_layer_accel_ce_macc_ctrl #(.C_CNT_WIDTH(CW), .C_MACC_LAT(4)) dut (
    .CLK            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_num_macc   (cfg_num_macc),
    .cfg_num_out    (cfg_num_out),
`ifdef CE_MACC_BIAS_EN
    .bias_valid_cfg (bias_valid_cfg),
`endif
    .busy           (busy),
    .done           (done),
    .bus            (bus),
    .dsp_ce         (dsp_ce),
    .dsp_rst        (dsp_rst),
    .dsp_opmode     (dsp_opmode),
    .dsp_alumode    (dsp_alumode)
  );

  // ---------------- behavioural DSP48E2 slice (A/B 2 regs, M, P) ----------
  logic [15:0] s_a1, s_a2, s_b1, s_b2;
  logic [31:0] s_m;
  logic [8:0]  s_opm;
  logic [47:0] s_p;

  always @(posedge clk) begin
    if (dsp_rst) begin
      s_a1 <= '0; s_a2 <= '0; s_b1 <= '0; s_b2 <= '0;
      s_m <= '0; s_opm <= '0; s_p <= '0;
    end else if (dsp_ce) begin
      s_a1  <= a_in;  s_a2 <= s_a1;
      s_b1  <= b_in;  s_b2 <= s_b1;
      s_m   <= 32'(s_a2) * 32'(s_b2);
      s_opm <= dsp_opmode;
      case (s_opm)
        OPMODE_LOAD_M: s_p <= {16'd0, s_m};
        OPMODE_ACC_M:  s_p <= s_p + {16'd0, s_m};
        OPMODE_BIAS_M: s_p <= C_BIAS + {16'd0, s_m};
        default:       s_p <= s_p;
      endcase
    end
  end

  // ---------------- checking ---------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (dot products from accepted beats) ----
  typedef struct { logic [47:0] sum; logic last; } res_t;
  res_t        exp_q[$];
  res_t        e;
  logic [47:0] got_q[$];
  logic [8:0]  opm_q[$];
  logic [47:0] m_acc = '0;
  int          m_beats = 0, m_nres = 0, m_nm = 1, m_no = 1;
  logic        m_bias = 1'b0;
  logic        done_due = 1'b0;
  int          res_cnt = 0, cyc = 0, last_acc_cyc = 0, first_ov_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      m_acc = '0; m_beats = 0; m_nres = 0; done_due = 1'b0;
    end else begin
      check("done_pulse", done, done_due);
      check("ce_rule", dsp_ce, !(bus.out_valid && !bus.out_ready));
      done_due = 1'b0;
      if (dsp_ce && dsp_opmode != OPMODE_HOLD) opm_q.push_back(dsp_opmode);
      if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (start && !busy) begin
        m_nm = (cfg_num_macc == 0) ? 1 : int'(cfg_num_macc);
        m_no = (cfg_num_out == 0) ? 1 : int'(cfg_num_out);
        m_bias = bias_valid_cfg; m_beats = 0; m_nres = 0; m_acc = '0;
      end
      if (bus.in_valid && bus.in_ready) begin
        last_acc_cyc = cyc;
        m_acc = ((m_beats == 0) ? (m_bias ? C_BIAS : 48'd0) : m_acc) + a_in * b_in;
        m_beats++;
        if (m_beats == m_nm) begin
          m_nres++;
          exp_q.push_back('{sum: m_acc, last: (m_nres == m_no)});
          m_beats = 0;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        res_cnt++;
        got_q.push_back(s_p);
        check("result_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("result_sum", s_p, e.sum);
          check("result_last", bus.out_last, e.last);
          done_due = e.last;
        end
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int nm, input int no, input logic bias);
    cfg_num_macc = CW'(nm); cfg_num_out = CW'(no); bias_valid_cfg = bias;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b);
    int n = 0; logic acc = 1'b0;
    bus.in_valid = 1'b1; a_in = a; b_in = b;
    while (!acc && n < 200) begin
      @(negedge clk); acc = bus.in_ready; tick(); n++;
    end
    check("beat_accepted", acc, 1'b1);
    bus.in_valid = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom);
  endtask

  task automatic send_bubble();
    bus.in_valid = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom); tick();
  endtask

  task automatic wait_done(input int budget);
    int n = 0; logic seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk); seen = done; n++;
    end
    check("job_done", seen, 1'b1);
    tick();
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 1'b0);         check("rst_done", done, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_opmode", dsp_opmode, 9'b000000000);
    check("rst_ce", dsp_ce, 1'b1);         check("rst_dsp_rst", dsp_rst, 1'b1);
  endtask

  // ---------------- test table --------------------------------------------
  typedef struct { int nm; int no; int vpct; int rpct; int exp_res; } vec_t;
  vec_t vecs[7];

  initial begin : main
    int r0, n;
    logic seen;
    logic [47:0] p_hold;
    logic [8:0]  exp_ops[6];
    vecs[0] = '{4, 1, 100, 100, 1};
    vecs[1] = '{3, 2, 70, 100, 2};
    vecs[2] = '{0, 3, 100, 100, 3};
    vecs[3] = '{1, 4, 60, 50, 4};
    vecs[4] = '{5, 0, 80, 60, 1};
    vecs[5] = '{2, 3, 50, 30, 3};
    vecs[6] = '{7, 2, 90, 80, 2};

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk); check_reset_outputs();
    tick(); rst = 1'b1; tick();

    // Test 1: back-to-back beats, opmode order and P latency.
    opm_q.delete(); got_q.delete(); first_ov_cyc = -1;
    start_job(4, 1, 1'b0);
    send_beat(1, 2); send_beat(3, 4); send_beat(5, 6); send_beat(7, 8);
    wait_done(100);
    check("t1_nops", opm_q.size(), 4);
    check("t1_op0", (opm_q.size() > 0) ? opm_q[0] : 9'h1ff, OPMODE_LOAD_M);
    for (int i = 1; i < 4; i++)
      check("t1_opacc", (opm_q.size() > i) ? opm_q[i] : 9'h1ff, OPMODE_ACC_M);
    check("t1_latency", 64'(first_ov_cyc - last_acc_cyc), 4);
    check("t1_sum", (got_q.size() > 0) ? got_q[0] : '1, 100);

    // Test 2: bubbles inside dot products leave the sum untouched.
    opm_q.delete(); got_q.delete();
    exp_ops = '{OPMODE_LOAD_M, OPMODE_ACC_M, OPMODE_ACC_M,
                OPMODE_LOAD_M, OPMODE_ACC_M, OPMODE_ACC_M};
    start_job(3, 2, 1'b0);
    send_beat(1, 2); send_bubble(); send_beat(3, 4); send_beat(5, 6);
    send_bubble(); send_bubble(); send_beat(7, 8); send_bubble();
    send_beat(9, 10); send_beat(11, 12);
    wait_done(100);
    check("t2_nops", opm_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check("t2_op", (opm_q.size() > i) ? opm_q[i] : 9'h1ff, exp_ops[i]);
    check("t2_sum0", (got_q.size() > 0) ? got_q[0] : '1, 44);
    check("t2_sum1", (got_q.size() > 1) ? got_q[1] : '1, 278);

    // Test 3: consumer stalls the first result while a beat is pending.
    r0 = res_cnt;
    bus.out_ready = 1'b0;
    start_job(2, 3, 1'b0);
    fork
      begin : p_send
        for (int i = 0; i < 6; i++) send_beat(16'(i + 3), 16'(2 * i + 1));
      end
      begin : p_stall
        n = 0;
        while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
        check("t3_ov_seen", bus.out_valid, 1'b1);
        p_hold = s_p;
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("t3_ce", dsp_ce, 1'b0);
          check("t3_in_ready", bus.in_ready, 1'b0);
          check("t3_out_valid", bus.out_valid, 1'b1);
          check("t3_p_held", s_p, p_hold);
        end
        tick(); bus.out_ready = 1'b1;
      end
    join
    wait_done(100);
    check("t3_results", res_cnt - r0, 3);

    // Table: randomized operands, gaps and backpressure.
    foreach (vecs[v]) begin
      r0 = res_cnt; n = 0; seen = 1'b0;
      start_job(vecs[v].nm, vecs[v].no, 1'b0);
      while (!seen && n < 3000) begin
        bus.in_valid  = ($urandom_range(99) < vecs[v].vpct);
        a_in          = 16'($urandom);
        b_in          = 16'($urandom);
        bus.out_ready = ($urandom_range(99) < vecs[v].rpct);
        @(negedge clk); seen = done; tick(); n++;
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      check("tbl_done", seen, 1'b1);
      check("tbl_results", res_cnt - r0, vecs[v].exp_res);
      check("tbl_drained", exp_q.size(), 0);
    end

    // Test 5: reset mid-job aborts it without done; a fresh job works.
    start_job(4, 2, 1'b0);
    send_beat(5, 5); send_beat(6, 6); send_beat(7, 7);
    rst = 1'b0; tick();
    @(negedge clk); check_reset_outputs();
    tick(); rst = 1'b1; tick();
    got_q.delete();
    start_job(2, 1, 1'b0);
    send_beat(2, 3); send_beat(4, 5);
    wait_done(100);
    check("t5_sum", (got_q.size() > 0) ? got_q[0] : '1, 26);

`ifdef CE_MACC_BIAS_EN
    // Test 6: C-port bias folded into the first beat.
    opm_q.delete(); got_q.delete();
    start_job(2, 1, 1'b1);
    send_beat(2, 3); send_beat(4, 5);
    wait_done(100);
    check("t6_op0", (opm_q.size() > 0) ? opm_q[0] : 9'h1ff, OPMODE_BIAS_M);
    check("t6_sum", (got_q.size() > 0) ? got_q[0] : '1, 126);
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
